gpll_apb_reconfig: RTL and testbench
====================================

// Module: gpll_apb_reconfig
// PURPOSE
//  APB initiator that dynamically reprograms a GTP_GPLL through its APB port.
//  Host loads up to DEPTH (addr,data) register writes, then pulses start.
//  Sequence: hold PLL in reset, issue the writes, release reset, wait for LOCK.
//  Sits between system control logic and the PLL wrapper's apb_*/rst/lock pins.
// PARAMETERS
//  DEPTH          8      entries in the write buffer (2..32)
//  RST_HOLD       16     apb_clk cycles pll_rst is held before the first write (>=1)
//  PREADY_TIMEOUT 255    max ACCESS cycles waiting for apb_ready before abort
//  LOCK_TIMEOUT   65535  max cycles after reset release waiting for synced lock
// PORTS
//  apb_clk     in   1   APB / control clock
//  apb_rst_n   in   1   asynchronous active-low reset
//  cfg_wr      in   1   push {cfg_addr,cfg_data} into buffer
//  cfg_addr    in   5   PLL register address
//  cfg_data    in   16  PLL register write data
//  cfg_full    out  1   buffer holds DEPTH entries
//  start       in   1   begin reconfiguration sequence (single-cycle pulse)
//  busy        out  1   sequence in progress
//  done        out  1   1-cycle pulse: sequence ended (success or error)
//  err         out  1   sequence failed; sticky until next accepted start
//  err_code    out  2   00 none, 01 apb_ready timeout, 10 lock timeout
//  pll_rst     out  1   to GTP_GPLL RST
//  pll_lock    in   1   from GTP_GPLL LOCK (asynchronous)
//  apb_addr    out  5   APB address
//  apb_sel     out  1   APB PSEL
//  apb_en      out  1   APB PENABLE
//  apb_write   out  1   APB PWRITE (always 1 during transfers)
//  apb_wdata   out  16  APB write data
//  apb_ready   in   1   APB PREADY from PLL
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffer count 0, lock synchroniser cleared.
//  pll_lock passes a 2-flop synchroniser (lock_s); all decisions use lock_s.
//  Buffer: cfg_wr accepted only in IDLE and !cfg_full; ignored otherwise.
//   cfg_full = (count==DEPTH). Entries issued in load order.
//  start accepted only in IDLE; ignored while busy. On accept: err/err_code clear.
//  FSM:
//   IDLE   -> RST when start; busy=1 from next cycle.
//   RST    pll_rst=1, counts RST_HOLD cycles; -> SETUP if count>0 else REL.
//   SETUP  apb_sel=1, apb_en=0, addr/wdata of current entry, apb_write=1; 1 cycle.
//   ACCESS apb_sel=1, apb_en=1; stays until apb_ready=1.
//          On ready: next entry -> SETUP, or last entry -> REL.
//          Waiting cycles > PREADY_TIMEOUT -> FAIL, err_code=01.
//   REL    pll_rst=0; 1 cycle -> LOCKW.
//   LOCKW  lock_s=1 -> FIN. Waiting cycles > LOCK_TIMEOUT -> FAIL, err_code=10.
//   FIN    done=1 for 1 cycle, count cleared -> IDLE.
//   FAIL   done=1, err=1; pll_rst=0; apb_sel/apb_en=0; count cleared -> IDLE.
//  pll_rst stays 1 from RST through the last ACCESS (PLL held in reset
//   for the whole write burst).
//  APB: addr/wdata/write stable across SETUP and ACCESS. apb_sel/apb_en never
//   drop mid-transfer except on timeout abort. Idle bus: apb_sel=apb_en=0.
//  Min transfer 2 cycles. Back-to-back entries have no idle cycle.
//  Counters saturate. Timeout compare is strictly greater.
//  Async reset mid-sequence: immediate return to IDLE with outputs 0.
//   pll_rst drops (PLL restarts with its static configuration).
// TESTING
//  1) Load 3 writes (0x02/0x0014, 0x03/0x0008, 0x04/0x0004), start, ready=1 always,
//     lock 50 cycles after release -> 3 SETUP/ACCESS pairs in order, pll_rst high
//     16+6 cycles, done pulse, err=0.
//  2) start with empty buffer -> RST_HOLD reset pulse, no APB activity,
//     done after lock.
//  3) apb_ready held 0 on 2nd write -> abort after 256 ACCESS cycles, err=1,
//     err_code=01, pll_rst=0, apb_sel=0.
//  4) lock never asserts (LOCK_TIMEOUT=100 in bench) -> err_code=10 at cycle 101
//     of LOCKW. Next start clears err.
//  5) Push 9 entries with DEPTH=8 -> cfg_full after 8th, 9th dropped.
//     cfg_wr/start during busy ignored.
//  6) apb_rst_n asserted during ACCESS -> all outputs 0 immediately.
//     After release, new load+start runs cleanly.

Source files
------------

// File: rtl/gpll_apb_reconfig.sv
// gpll_apb_reconfig: APB initiator that reprograms a GTP_GPLL at run time.
// The host loads up to DEPTH (addr,data) writes while idle, then pulses start.
// The block holds the PLL in reset, issues the buffered APB writes in load
// order, releases reset and waits for the (synchronised) lock indication.
module gpll_apb_reconfig #(
    parameter int DEPTH          = 8,
    parameter int RST_HOLD       = 16,
    parameter int PREADY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT   = 65535
) (
    input  logic        apb_clk_i,
    input  logic        apb_rst_n_i,
    input  logic        cfg_wr_i,
    input  logic [4:0]  cfg_addr_i,
    input  logic [15:0] cfg_data_i,
    output logic        cfg_full_o,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        pll_rst_o,
    input  logic        pll_lock_i,
    output logic [4:0]  apb_addr_o,
    output logic        apb_sel_o,
    output logic        apb_en_o,
    output logic        apb_write_o,
    output logic [15:0] apb_wdata_o,
    input  logic        apb_ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MAX_A = (RST_HOLD > PREADY_TIMEOUT) ? RST_HOLD : PREADY_TIMEOUT;
    localparam int MAX_T = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int TMR_W = $clog2(MAX_T + 2);

    localparam logic [TMR_W-1:0] TMR_ONE_C   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO_C  = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_MAX_C   = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0] RST_LAST_C  = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0] PREADY_TO_C = TMR_W'(PREADY_TIMEOUT);
    localparam logic [TMR_W-1:0] LOCK_TO_C   = TMR_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE_C   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO_C  = PTR_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_REL    = 3'd4,
        ST_LOCKW  = 3'd5,
        ST_FIN    = 3'd6,
        ST_FAIL   = 3'd7
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               cfg_full_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [1:0]         err_code_q;
    logic               pll_rst_q;
    logic [4:0]         apb_addr_q;
    logic               apb_sel_q;
    logic               apb_en_q;
    logic               apb_write_q;
    logic [15:0]        apb_wdata_q;
    logic               lock_meta_q;
    logic               lock_sync_q;

    logic [4:0]         addr_mem_q [DEPTH];
    logic [15:0]        data_mem_q [DEPTH];

    logic               push_s;
    logic               last_s;
    logic [TMR_W-1:0]   tmr_inc_s;
    logic [PTR_W-1:0]   ptr_next_s;

    assign push_s     = cfg_wr_i && (state_q == ST_IDLE) && !cfg_full_q;
    assign last_s     = ((CNT_W'(ptr_q) + CNT_ONE_C) == count_q);
    assign tmr_inc_s  = (tmr_q == TMR_MAX_C) ? tmr_q : (tmr_q + TMR_ONE_C);
    assign ptr_next_s = ptr_q + PTR_ONE_C;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge apb_clk_i or negedge apb_rst_n_i) begin
        if (!apb_rst_n_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Write buffer storage; the slot index is the current fill count.
    always_ff @(posedge apb_clk_i) begin
        if (push_s) begin
            addr_mem_q[count_q[PTR_W-1:0]] <= cfg_addr_i;
            data_mem_q[count_q[PTR_W-1:0]] <= cfg_data_i;
        end
    end

    // Sequencer: buffer bookkeeping, PLL reset, APB transfers and lock wait.
    always_ff @(posedge apb_clk_i or negedge apb_rst_n_i) begin
        if (!apb_rst_n_i) begin
            state_q     <= ST_IDLE;
            count_q     <= CNT_ZERO_C;
            ptr_q       <= PTR_ZERO_C;
            tmr_q       <= TMR_ZERO_C;
            cfg_full_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            pll_rst_q   <= 1'b0;
            apb_addr_q  <= 5'd0;
            apb_sel_q   <= 1'b0;
            apb_en_q    <= 1'b0;
            apb_write_q <= 1'b0;
            apb_wdata_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (push_s) begin
                        count_q    <= count_q + CNT_ONE_C;
                        cfg_full_q <= ((count_q + CNT_ONE_C) == DEPTH_C);
                    end
                    if (start_i) begin
                        state_q    <= ST_RST;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        pll_rst_q  <= 1'b1;
                        tmr_q      <= TMR_ZERO_C;
                        ptr_q      <= PTR_ZERO_C;
                    end
                end
                ST_RST: begin
                    if (tmr_q == RST_LAST_C) begin
                        tmr_q <= TMR_ZERO_C;
                        if (count_q != CNT_ZERO_C) begin
                            state_q     <= ST_SETUP;
                            apb_sel_q   <= 1'b1;
                            apb_en_q    <= 1'b0;
                            apb_write_q <= 1'b1;
                            apb_addr_q  <= addr_mem_q[ptr_q];
                            apb_wdata_q <= data_mem_q[ptr_q];
                        end else begin
                            state_q   <= ST_REL;
                            pll_rst_q <= 1'b0;
                        end
                    end else begin
                        tmr_q <= tmr_inc_s;
                    end
                end
                ST_SETUP: begin
                    state_q  <= ST_ACCESS;
                    apb_en_q <= 1'b1;
                    tmr_q    <= TMR_ZERO_C;
                end
                ST_ACCESS: begin
                    if (apb_ready_i) begin
                        apb_en_q <= 1'b0;
                        tmr_q    <= TMR_ZERO_C;
                        if (last_s) begin
                            state_q     <= ST_REL;
                            apb_sel_q   <= 1'b0;
                            apb_write_q <= 1'b0;
                            pll_rst_q   <= 1'b0;
                        end else begin
                            state_q     <= ST_SETUP;
                            ptr_q       <= ptr_next_s;
                            apb_addr_q  <= addr_mem_q[ptr_next_s];
                            apb_wdata_q <= data_mem_q[ptr_next_s];
                        end
                    end else if (tmr_q == PREADY_TO_C) begin
                        // Slave never answered: abort the transfer and let the PLL restart.
                        state_q     <= ST_FAIL;
                        apb_sel_q   <= 1'b0;
                        apb_en_q    <= 1'b0;
                        apb_write_q <= 1'b0;
                        pll_rst_q   <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        err_code_q  <= 2'b01;
                    end else begin
                        tmr_q <= tmr_inc_s;
                    end
                end
                ST_REL: begin
                    state_q <= ST_LOCKW;
                    tmr_q   <= TMR_ZERO_C;
                end
                ST_LOCKW: begin
                    if (lock_sync_q) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else if (tmr_q == LOCK_TO_C) begin
                        state_q    <= ST_FAIL;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                    end else begin
                        tmr_q <= tmr_inc_s;
                    end
                end
                ST_FIN, ST_FAIL: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    count_q    <= CNT_ZERO_C;
                    cfg_full_q <= 1'b0;
                    ptr_q      <= PTR_ZERO_C;
                    tmr_q      <= TMR_ZERO_C;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    pll_rst_q   <= 1'b0;
                    apb_sel_q   <= 1'b0;
                    apb_en_q    <= 1'b0;
                    apb_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_full_o  = cfg_full_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign pll_rst_o   = pll_rst_q;
    assign apb_addr_o  = apb_addr_q;
    assign apb_sel_o   = apb_sel_q;
    assign apb_en_o    = apb_en_q;
    assign apb_write_o = apb_write_q;
    assign apb_wdata_o = apb_wdata_q;

endmodule

// File: tb/tb_gpll_apb_reconfig.sv
// Scoreboard bench for gpll_apb_reconfig: stimulus pushes expected APB writes
// and end-of-sequence records; a negedge monitor pops and compares them.
module tb_gpll_apb_reconfig;

    logic        clk;
    logic        rst_n;
    logic        cfg_wr;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_full;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        pll_rst;
    logic        pll_lock;
    logic [4:0]  apb_addr;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic [15:0] apb_wdata;
    logic        apb_ready;

    gpll_apb_reconfig #(
        .DEPTH(8), .RST_HOLD(16), .PREADY_TIMEOUT(255), .LOCK_TIMEOUT(100)
    ) dut (
        .apb_clk_i(clk), .apb_rst_n_i(rst_n),
        .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
        .cfg_full_o(cfg_full), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .err_code_o(err_code), .pll_rst_o(pll_rst),
        .pll_lock_i(pll_lock), .apb_addr_o(apb_addr), .apb_sel_o(apb_sel),
        .apb_en_o(apb_en), .apb_write_o(apb_write), .apb_wdata_o(apb_wdata),
        .apb_ready_i(apb_ready)
    );

    typedef struct {
        bit          is_done;
        logic [4:0]  addr;
        logic [15:0] data;
        int          err;
        int          code;
        int          rst_hi;
        int          stall;
        int          post;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   lock_delay = 1000000;
    int   rst_hi_cnt = 0;
    int   stall_cnt  = 0;
    int   post_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs_packed();
        return int'({busy, done, err, err_code, pll_rst, apb_sel, apb_en,
                     apb_write, cfg_full, apb_addr, apb_wdata});
    endfunction

    task automatic exp_apb(input logic [4:0] a, input logic [15:0] d);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d;
        e.err = 0; e.code = 0; e.rst_hi = 0; e.stall = 0; e.post = 0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int e_err, input int e_code, input int e_rst_hi,
                            input int e_stall, input int e_post);
        exp_t e;
        e.is_done = 1'b1; e.addr = 5'd0; e.data = 16'd0;
        e.err = e_err; e.code = e_code; e.rst_hi = e_rst_hi;
        e.stall = e_stall; e.post = e_post;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_access(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (apb_sel && apb_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s: no ACCESS phase within %0d cycles", name, budget);
        end
    endtask

    // PLL lock model: lock rises lock_delay cycles after reset release while busy.
    initial begin
        int rel_cnt;
        rel_cnt  = 0;
        pll_lock = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy || pll_rst) begin
                rel_cnt  = 0;
                pll_lock = 1'b0;
            end else begin
                rel_cnt++;
                if (rel_cnt >= lock_delay) pll_lock = 1'b1;
            end
        end
    end

    // Monitor: count phases, compare completed APB writes and done records.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rst_hi_cnt = 0; stall_cnt = 0; post_cnt = 0;
            end else begin
                if (pll_rst) rst_hi_cnt++;
                if (apb_sel && apb_en && !apb_ready) stall_cnt++;
                if (busy && !pll_rst && !done) post_cnt++;
                if (apb_sel && apb_en && apb_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("apb_unexpected", int'(apb_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("apb_kind", 0, int'(e.is_done));
                        chk("apb_addr", int'(apb_addr), int'(e.addr));
                        chk("apb_wdata", int'(apb_wdata), int'(e.data));
                        chk("apb_write", int'(apb_write), 1);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", int'(err_code), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_kind", 1, int'(e.is_done));
                        chk("done_err", int'(err), e.err);
                        chk("done_err_code", int'(err_code), e.code);
                        chk("pll_rst_cycles", rst_hi_cnt, e.rst_hi);
                        chk("ready_stall_cycles", stall_cnt, e.stall);
                        chk("post_release_cycles", post_cnt, e.post);
                        chk("done_bus_idle", int'({apb_sel, apb_en, pll_rst}), 0);
                    end
                    rst_hi_cnt = 0; stall_cnt = 0; post_cnt = 0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = 5'd0; cfg_data = 16'd0;
        start = 1'b0; apb_ready = 1'b1;
        #12;
        chk("reset_outputs", outs_packed(), 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_outputs", outs_packed(), 0);

        // 1) three writes, lock 50 cycles after release
        load(5'h02, 16'h0014); load(5'h03, 16'h0008); load(5'h04, 16'h0004);
        exp_apb(5'h02, 16'h0014); exp_apb(5'h03, 16'h0008); exp_apb(5'h04, 16'h0004);
        exp_done(0, 0, 22, 0, 52);
        lock_delay = 50;
        pulse_start();
        chk("t1_busy_after_start", int'(busy), 1);
        wait_done(300, "t1_done");
        chk("t1_err_after", int'(err), 0);

        // 2) empty buffer: reset pulse only
        lock_delay = 10;
        exp_done(0, 0, 16, 0, 12);
        pulse_start();
        wait_done(200, "t2_done");

        // 3) ready stuck low on the second write
        load(5'h05, 16'h1234); load(5'h06, 16'h5678);
        exp_apb(5'h05, 16'h1234);
        exp_done(1, 1, 275, 256, 0);
        pulse_start();
        wait_access(100, "t3_first_access");
        @(posedge clk); #1;
        apb_ready = 1'b0;
        wait_done(400, "t3_done");
        apb_ready = 1'b1;
        chk("t3_err_sticky", int'(err), 1);
        chk("t3_err_code_sticky", int'(err_code), 1);
        chk("t3_bus_idle", int'({pll_rst, apb_sel, apb_en}), 0);

        // 4) lock never arrives; start clears the previous error
        lock_delay = 1000000;
        load(5'h07, 16'h00AA);
        exp_apb(5'h07, 16'h00AA);
        exp_done(1, 2, 18, 0, 102);
        pulse_start();
        chk("t4_err_cleared_on_start", int'({err, err_code}), 0);
        wait_done(400, "t4_done");
        chk("t4_err_code_sticky", int'(err_code), 2);

        // 5) overfill, then cfg_wr/start while busy are ignored
        for (int i = 0; i < 7; i++) load(5'(8 + i), 16'hA000 + 16'(i));
        chk("t5_not_full_at_7", int'(cfg_full), 0);
        load(5'h0F, 16'hA007);
        chk("t5_full_at_8", int'(cfg_full), 1);
        load(5'h1F, 16'hFFFF);
        chk("t5_full_after_9th", int'(cfg_full), 1);
        for (int i = 0; i < 8; i++) exp_apb(5'(8 + i), 16'hA000 + 16'(i));
        lock_delay = 5;
        exp_done(0, 0, 32, 0, 7);
        pulse_start();
        chk("t5_err_cleared_on_start", int'({err, err_code}), 0);
        repeat (3) @(posedge clk);
        #1;
        load(5'h1E, 16'hEEEE);
        pulse_start();
        wait_done(300, "t5_done");
        chk("t5_buffer_cleared", int'({cfg_full, busy}), 0);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_restart", int'(busy), 0);

        // 6) async reset during ACCESS, then a clean run
        load(5'h10, 16'h0101); load(5'h11, 16'h0202);
        apb_ready = 1'b0;
        pulse_start();
        wait_access(100, "t6_access");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", outs_packed(), 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_ready = 1'b1;
        load(5'h12, 16'h0303); load(5'h13, 16'h0404);
        exp_apb(5'h12, 16'h0303); exp_apb(5'h13, 16'h0404);
        lock_delay = 3;
        exp_done(0, 0, 20, 0, 5);
        pulse_start();
        wait_done(200, "t6_done");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
